// File: rtl/mc_main_control_if.sv
// Control bus between the multicycle main FSM and the datapath.
// master drives opcode/zero/mem_ready, slave is the control FSM.
interface mc_main_control_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic [1:0] ALUOp;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic       PCWrite;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       illegal;
  logic [3:0] state;

  modport master (
    output opcode, zero, mem_ready,
    input  ALUOp, ALUSrcA, ALUSrcB, PCSource, PCWrite,
    input  IorD, MemRead, MemWrite, IRWrite,
    input  RegDst, MemtoReg, RegWrite, illegal, state
  );

  modport slave (
    input  opcode, zero, mem_ready,
    output ALUOp, ALUSrcA, ALUSrcB, PCSource, PCWrite,
    output IorD, MemRead, MemWrite, IRWrite,
    output RegDst, MemtoReg, RegWrite, illegal, state
  );
endinterface

// File: rtl/mc_main_control.sv
// Multicycle main control FSM: sequences fetch/decode/execute and
// drives every datapath enable, mux select and the 2-bit ALUOp.
module mc_main_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input logic               clk,
  input logic               rst,
  mc_main_control_if.slave  bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  state_t r_state;
  logic   r_is_load;
  logic   w_known_op;

  assign w_known_op = (bus.opcode == OP_RTYPE) ||
                      (bus.opcode == OP_LW)    ||
                      (bus.opcode == OP_SW)    ||
                      (bus.opcode == OP_BEQ)   ||
                      (bus.opcode == OP_J)     ||
                      (bus.opcode == OP_ADDI);

  // State sequencing; opcode is only looked at in DECODE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_is_load <= 1'b0;
    end else begin
      unique case (r_state)
        S_FETCH:  if (bus.mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          r_is_load <= (bus.opcode == OP_LW);
          if (bus.opcode == OP_LW || bus.opcode == OP_SW)
            r_state <= S_MEMADR;
          else if (bus.opcode == OP_RTYPE)
            r_state <= S_EXEC;
          else if (bus.opcode == OP_BEQ)
            r_state <= S_BRANCH;
          else if (bus.opcode == OP_J)
            r_state <= S_JUMP;
          else if (bus.opcode == OP_ADDI)
            r_state <= S_ADDIEX;
          else
            r_state <= S_FETCH;
        end
        S_MEMADR: r_state <= r_is_load ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (bus.mem_ready) r_state <= S_MEMWB;
        S_MEMWB:  r_state <= S_FETCH;
        S_MEMWR:  if (bus.mem_ready) r_state <= S_FETCH;
        S_EXEC:   r_state <= S_ALUWB;
        S_ALUWB:  r_state <= S_FETCH;
        S_BRANCH: r_state <= S_FETCH;
        S_JUMP:   r_state <= S_FETCH;
        S_ADDIEX: r_state <= S_ADDIWB;
        S_ADDIWB: r_state <= S_FETCH;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  // Moore decode of state; rst gates everything so no write survives it.
  always_comb begin
    bus.ALUOp    = 2'b00;
    bus.ALUSrcA  = 1'b0;
    bus.ALUSrcB  = 2'b00;
    bus.PCSource = 2'b00;
    bus.PCWrite  = 1'b0;
    bus.IorD     = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.RegDst   = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.RegWrite = 1'b0;
    bus.illegal  = 1'b0;
    bus.state    = r_state;
    if (rst) begin
      bus.state = S_FETCH;
    end else begin
      unique case (r_state)
        S_FETCH: begin
          bus.MemRead = 1'b1;
          bus.ALUSrcB = 2'b01;
          bus.IRWrite = bus.mem_ready;
          bus.PCWrite = bus.mem_ready;
        end
        S_DECODE: begin
          bus.ALUSrcB = 2'b11;
          bus.illegal = ~w_known_op;
        end
        S_MEMADR: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          bus.MemRead = 1'b1;
          bus.IorD    = 1'b1;
        end
        S_MEMWB: begin
          bus.MemtoReg = 1'b1;
          bus.RegWrite = 1'b1;
        end
        S_MEMWR: begin
          bus.MemWrite = 1'b1;
          bus.IorD     = 1'b1;
        end
        S_EXEC: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUOp   = 2'b10;
        end
        S_ALUWB: begin
          bus.RegDst   = 1'b1;
          bus.RegWrite = 1'b1;
        end
        S_BRANCH: begin
          bus.ALUSrcA  = 1'b1;
          bus.ALUOp    = 2'b01;
          bus.PCSource = 2'b01;
          bus.PCWrite  = bus.zero;
        end
        S_JUMP: begin
          bus.PCSource = 2'b10;
          bus.PCWrite  = 1'b1;
        end
        S_ADDIEX: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = 2'b10;
        end
        S_ADDIWB: begin
          bus.RegWrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_main_control.sv
// Scoreboard bench for the multicycle main control FSM:
// random instruction streams against a path-list reference model.
module tb_mc_main_control;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef struct packed {
    logic [3:0] st;
    logic [1:0] aluop;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic       pcw;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       rdst;
    logic       m2r;
    logic       rw;
    logic       ill;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  obs_t sb[$];

  mc_main_control_if bus ();

  mc_main_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic obs_t dut_obs();
    obs_t o;
    o.st    = bus.state;
    o.aluop = bus.ALUOp;
    o.srca  = bus.ALUSrcA;
    o.srcb  = bus.ALUSrcB;
    o.pcsrc = bus.PCSource;
    o.pcw   = bus.PCWrite;
    o.iord  = bus.IorD;
    o.mrd   = bus.MemRead;
    o.mwr   = bus.MemWrite;
    o.irw   = bus.IRWrite;
    o.rdst  = bus.RegDst;
    o.m2r   = bus.MemtoReg;
    o.rw    = bus.RegWrite;
    o.ill   = bus.illegal;
    return o;
  endfunction

  function automatic bit known(input logic [5:0] op);
    return op == OP_RTYPE || op == OP_LW || op == OP_SW ||
           op == OP_BEQ || op == OP_J || op == OP_ADDI;
  endfunction

  // Expected control word for one cycle, straight from the state table.
  function automatic obs_t expv(input logic [3:0] st, input logic mr,
                                input logic z, input logic [5:0] op);
    obs_t e;
    e = '0;
    e.st = st;
    case (st)
      4'd0:  begin e.mrd = 1; e.srcb = 2'b01; e.irw = mr; e.pcw = mr; end
      4'd1:  begin e.srcb = 2'b11; e.ill = !known(op); end
      4'd2:  begin e.srca = 1; e.srcb = 2'b10; end
      4'd3:  begin e.mrd = 1; e.iord = 1; end
      4'd4:  begin e.m2r = 1; e.rw = 1; end
      4'd5:  begin e.mwr = 1; e.iord = 1; end
      4'd6:  begin e.srca = 1; e.aluop = 2'b10; end
      4'd7:  begin e.rdst = 1; e.rw = 1; end
      4'd8:  begin
        e.srca = 1; e.aluop = 2'b01; e.pcsrc = 2'b01; e.pcw = z;
      end
      4'd9:  begin e.pcsrc = 2'b10; e.pcw = 1; end
      4'd10: begin e.srca = 1; e.srcb = 2'b10; end
      4'd11: begin e.rw = 1; end
      default: ;
    endcase
    return e;
  endfunction

  // Monitor: every cycle with a queued expectation is compared.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      obs_t e;
      obs_t g;
      e = sb.pop_front();
      g = dut_obs();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL cycle %0d st%0d got=%h exp=%h", cyc, e.st, g, e);
      end
    end
  end

  // Drive one cycle now (just after a rising edge) and queue its expectation.
  task automatic play(input logic [3:0] st, input logic mr,
                      input logic [5:0] op, input int zsel);
    logic z;
    z = (zsel < 0) ? 1'($urandom) : (zsel != 0);
    bus.mem_ready = mr;
    bus.zero      = z;
    bus.opcode    = (st == 4'd1) ? op : 6'($urandom);
    sb.push_back(expv(st, mr, z, op));
    @(posedge clk);
    #1;
  endtask

  // One instruction: its state path is a fixed list per opcode class.
  task automatic run_instr(input logic [5:0] op, input int wf,
                           input int wm, input int zsel);
    logic [3:0] path[$];
    path = {};
    case (op)
      OP_RTYPE: path = {4'd1, 4'd6, 4'd7};
      OP_LW:    path = {4'd1, 4'd2, 4'd3, 4'd4};
      OP_SW:    path = {4'd1, 4'd2, 4'd5};
      OP_BEQ:   path = {4'd1, 4'd8};
      OP_J:     path = {4'd1, 4'd9};
      OP_ADDI:  path = {4'd1, 4'd10, 4'd11};
      default:  path = {4'd1};
    endcase
    repeat (wf) play(4'd0, 1'b0, op, zsel);
    play(4'd0, 1'b1, op, zsel);
    foreach (path[i]) begin
      if (path[i] == 4'd3 || path[i] == 4'd5) begin
        repeat (wm) play(path[i], 1'b0, op, zsel);
        play(path[i], 1'b1, op, zsel);
      end else begin
        play(path[i], 1'($urandom), op, zsel);
      end
    end
  endtask

  task automatic check(input string nm, input logic [7:0] got,
                       input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() > 0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain got=%0d exp=0", sb.size());
      sb = {};
    end
  endtask

  initial begin
    logic [5:0] ops[6];
    ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    bus.opcode    = OP_LW;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state_outs", {7'd0, dut_obs() != '0}, 8'd0);
    check("rst_mrd", {7'd0, bus.MemRead}, 8'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // directed scenarios
    run_instr(OP_RTYPE, 0, 0, -1);
    run_instr(OP_LW, 0, 2, -1);
    run_instr(OP_BEQ, 0, 0, 1);
    run_instr(OP_BEQ, 0, 0, 0);
    run_instr(OP_J, 0, 0, -1);
    run_instr(OP_SW, 0, 0, -1);
    run_instr(6'b111111, 0, 0, -1);
    run_instr(OP_ADDI, 2, 0, -1);

    // random stream with random stalls and random illegal opcodes
    for (int n = 0; n < 300; n++) begin
      logic [5:0] op;
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 5)];
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), -1);
    end
    drain();

    // asynchronous reset in the middle of a load writeback
    play(4'd0, 1'b1, OP_LW, -1);
    play(4'd1, 1'b1, OP_LW, -1);
    play(4'd2, 1'b1, OP_LW, -1);
    play(4'd3, 1'b1, OP_LW, -1);
    drain();
    bus.mem_ready = 1'b1;
    #2;
    check("memwb_state", {4'd0, bus.state}, 8'd4);
    check("memwb_rw", {7'd0, bus.RegWrite}, 8'd1);
    rst = 1'b1;
    #1;
    check("async_state", {4'd0, bus.state}, 8'd0);
    check("async_rw", {7'd0, bus.RegWrite}, 8'd0);
    check("async_mrd", {7'd0, bus.MemRead}, 8'd0);
    @(posedge clk);
    #1;
    check("rst_hold", {7'd0, dut_obs() != '0}, 8'd0);
    rst = 1'b0;
    run_instr(OP_RTYPE, 0, 0, -1);
    run_instr(OP_LW, 1, 1, -1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_main_control.md
Name: mc_main_control

Overview:
- Multicycle main control FSM for the 32-bit processor.
- Sits directly upstream of the ALU control decoder: produces the 2-bit ALUOp that the decoder combines with funct to form ALUctrl.
- Also drives all datapath enables and muxes: PC, IR, memory, register file, and ALU source selects.
- Consumes the IR opcode, the ALU zero flag and a memory ready handshake.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word opcode
- OP_SW, 6'b101011, store word opcode
- OP_BEQ, 6'b000100, branch-equal opcode
- OP_J, 6'b000010, jump opcode
- OP_ADDI, 6'b001000, add-immediate opcode

Ports:
- clk in 1 system clock, rising edge
- rst in 1 asynchronous active-high reset
- opcode in 6 IR[31:26]; sampled only in DECODE
- zero in 1 ALU zero flag
- mem_ready in 1 memory access completes this cycle
- ALUOp out 2 00 add, 01 sub, 10 funct-defined; 11 never driven
- ALUSrcA out 1 0 = PC, 1 = reg A
- ALUSrcB out 2 00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- PCSource out 2 00 = ALU result, 01 = ALUOut, 10 = jump target
- PCWrite out 1 PC load enable (branch qualification included)
- IorD out 1 memory address select (0 = PC, 1 = ALUOut)
- MemRead out 1 memory read request
- MemWrite out 1 memory write request
- IRWrite out 1 instruction register load
- RegDst out 1 0 = rt, 1 = rd
- MemtoReg out 1 0 = ALUOut, 1 = MDR
- RegWrite out 1 register file write enable
- illegal out 1 one-cycle pulse on unsupported opcode
- state out 4 current state, for debug and bench

Behaviour:
- Moore FSM; state register is 4 bits. Outputs are combinational from state, except PCWrite (uses zero/mem_ready) and IRWrite (uses mem_ready).
- Any output not listed for a state is 0.
- rst asserted (async):
  - state = FETCH (0).
  - All outputs forced 0 while rst is high, including MemRead.
  - First fetch occurs in the first clock after rst deasserts.
  - rst mid-instruction aborts it; no partial write completes after the rst edge.
- FETCH (0):
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite = PCWrite = mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE (1): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute). Next state by opcode:
  - lw/sw -> MEMADR (2)
  - R-type -> EXEC (6)
  - beq -> BRANCH (8)
  - j -> JUMP (9)
  - addi -> ADDIEX (10)
  - any other opcode -> FETCH, with illegal=1 this cycle
- MEMADR (2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw -> MEMRD; sw -> MEMWR. Uses the opcode captured at DECODE into an internal 1-bit is_load flag.
- MEMRD (3): MemRead=1, IorD=1. Wait for mem_ready, then MEMWB.
- MEMWB (4): RegDst=0, MemtoReg=1, RegWrite=1. Next: FETCH.
- MEMWR (5): MemWrite=1, IorD=1. Wait for mem_ready, then FETCH.
- EXEC (6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: ALUWB.
- ALUWB (7): RegDst=1, MemtoReg=0, RegWrite=1. Next: FETCH.
- BRANCH (8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCWrite=zero. Next: FETCH.
- JUMP (9): PCSource=10, PCWrite=1. Next: FETCH.
- ADDIEX (10): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: ADDIWB.
- ADDIWB (11): RegDst=0, MemtoReg=0, RegWrite=1. Next: FETCH.
- Unused encodings 12-15 return to FETCH with all outputs 0.
- Latency with mem_ready tied 1, in clocks including FETCH:
  - R-type 4, lw 5, sw 4, beq 3, j 3, addi 4.
- Each mem_ready=0 cycle adds one clock in the state that is waiting.
- MemRead and MemWrite are never both 1. RegWrite and PCWrite are never both 1.
- opcode changes outside DECODE are ignored.

Test Plan:
- Reset: hold rst=1 across two edges with mem_ready=1 -> state=0 and every output 0. Release rst -> next cycle MemRead=1, ALUSrcB=01, IRWrite=1, PCWrite=1.
- R-type: opcode=000000, mem_ready=1 -> state sequence 0,1,6,7,0. ALUOp=10 only in state 6. RegDst=1, RegWrite=1 in state 7.
- lw with wait: opcode=100011, mem_ready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0. MemRead=1, IorD=1 throughout state 3. MemtoReg=1, RegWrite=1 in state 4.
- beq: opcode=000100 with zero=1 -> PCWrite=1, PCSource=01, ALUOp=01 in state 8. Repeat with zero=0 -> PCWrite=0, sequence 0,1,8,0.
- j and sw: opcode=000010 -> states 0,1,9,0 with PCSource=10, PCWrite=1. opcode=101011 -> states 0,1,2,5,0 with MemWrite=1 in state 5 only.
- Illegal and async reset: opcode=111111 -> illegal=1 in DECODE, next state 0. Assert rst asynchronously mid-MEMWB -> state=0 immediately and RegWrite drops to 0 without waiting for a clock edge.
